// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the framebuffer arbiter.
//   FB_ADDR_W    : default framebuffer word-address width (512 x 32-bit words)
//   FB_BASE_ADDR : default Wishbone byte base address of the framebuffer window
//   fb_state_t   : Wishbone transaction FSM states
package gfx_pkg;

    localparam int          FB_ADDR_W    = 9;
    localparam logic [31:0] FB_BASE_ADDR = 32'h3000_0000;

    // IDLE: accepting a new Wishbone cycle
    // WAIT: memory access issued, read data arrives this cycle
    // ACK : acknowledge pulse presented to the master
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Wishbone classic bus bundle used between a master and the framebuffer arbiter.
//   cyc, stb, we : cycle / strobe / write-enable controls (master -> slave)
//   adr, dat_w   : byte address and write data (master -> slave)
//   sel          : byte enables (master -> slave)
//   dat_r, ack   : read data and acknowledge (slave -> master)
interface fb_arbiter_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack
    );

endinterface

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: shares one single-port SRAM between a scanout reader
// and a Wishbone classic slave port.
//   clk, reset_n : clock and asynchronous active-low reset
//   wb           : Wishbone slave bundle (cyc/stb/we/adr/dat_w/sel in, dat_r/ack out)
//   scan_req, scan_addr          : scanout read request and word address
//   scan_gnt                     : scanout granted this cycle (combinational)
//   scan_valid, scan_data        : read data for the scan grant of the previous cycle
//   mem_en, mem_we, mem_wmask,
//   mem_addr, mem_wdata, mem_rdata : SRAM port, read data valid one cycle after mem_en
// Scanout wins by default; a waiting Wishbone cycle takes the memory once
// STARVE_MAX scan grants have gone by while it was pending.
module fb_arbiter
    import gfx_pkg::*;
#(
    parameter int          ADDR_W     = FB_ADDR_W,
    parameter logic [31:0] BASE_ADDR  = FB_BASE_ADDR,
    parameter int          STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    fb_arbiter_if.slave       wb,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_valid,
    output logic [31:0]       scan_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    fb_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              scan_valid_reg;
    logic              ack_reg;
    logic [31:0]       dat_r_reg;
    logic              rd_hit_reg;   // granted cycle was an in-range read
    logic              oor_reg;      // granted cycle was outside the window

    logic              wb_pending;
    logic              in_range;
    logic [ADDR_W-1:0] wb_word;
    logic              wb_grant;
    logic              scan_grant;
    logic              unused_adr_bits;

    assign wb_pending      = wb.cyc & wb.stb & (state_reg == IDLE);
    assign in_range        = (wb.adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign wb_word         = wb.adr[ADDR_W+1:2];
    assign unused_adr_bits = ^wb.adr[1:0];

    // Arbitration, starvation counter, FSM next state and SRAM port.
    // Everything is gated by reset_n so the memory is untouched while in reset.
    always_comb begin
        wb_grant        = 1'b0;
        scan_grant      = 1'b0;
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_wmask       = 4'b0000;
        mem_addr        = '0;
        mem_wdata       = 32'h0;

        if (reset_n) begin
            if (wb_pending && (!scan_req || (starve_cnt_reg == CNT_MAX))) begin
                wb_grant = 1'b1;
            end else if (scan_req) begin
                scan_grant = 1'b1;
            end
        end

        // Counts scan grants that overtook a waiting Wishbone cycle.
        if (!wb_pending || wb_grant) begin
            starve_cnt_next = '0;
        end else if (scan_grant && (starve_cnt_reg != CNT_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end

        case (state_reg)
            IDLE:    if (wb_grant) state_next = WAIT;
            WAIT:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (scan_grant) begin
            mem_en   = 1'b1;
            mem_addr = scan_addr;
        end else if (wb_grant && in_range) begin
            mem_en    = 1'b1;
            mem_we    = wb.we;
            mem_addr  = wb_word;
            mem_wmask = wb.we ? wb.sel : 4'b0000;
            mem_wdata = wb.dat_w;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            scan_valid_reg <= 1'b0;
            ack_reg        <= 1'b0;
            dat_r_reg      <= 32'h0;
            rd_hit_reg     <= 1'b0;
            oor_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            scan_valid_reg <= scan_grant;

            if (wb_grant) begin
                rd_hit_reg <= in_range & ~wb.we;
                oor_reg    <= ~in_range;
            end

            // SRAM read data for the Wishbone grant is on mem_rdata during WAIT.
            // Writes leave the read-data register untouched.
            if (state_reg == WAIT) begin
                if (rd_hit_reg) begin
                    dat_r_reg <= mem_rdata;
                end else if (oor_reg) begin
                    dat_r_reg <= 32'h0;
                end
            end

            // A master that dropped the cycle before ACK gets no pulse;
            // a write has already been committed by then.
            ack_reg <= (state_reg == WAIT) & wb.cyc & wb.stb;
        end
    end

    assign scan_gnt   = scan_grant;
    assign scan_valid = scan_valid_reg;
    assign scan_data  = scan_valid_reg ? mem_rdata : 32'h0;
    assign wb.ack     = ack_reg;
    assign wb.dat_r   = dat_r_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: behavioural SRAM, reference memory image,
// scoreboard queues for scanout data and Wishbone read data.
module tb_fb_arbiter;
    import gfx_pkg::*;

    localparam int          ADDR_W     = 9;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] BASE       = 32'h3000_0000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_gnt;
    logic              scan_valid;
    logic [31:0]       scan_data;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_wmask;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    fb_arbiter_if wb();

    always #5 clk = ~clk;

    fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb         (wb.slave),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_gnt   (scan_gnt),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_wmask  (mem_wmask),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural single-port SRAM driven only by the DUT.
    logic [31:0] sram    [0:511];
    // What the memory should hold, updated from the stimulus intent.
    logic [31:0] ref_mem [0:511];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } wb_exp_t;

    logic [31:0] scan_q [$];
    wb_exp_t     wb_q   [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        wb_exp_t     w;
        if (reset_n === 1'b1) begin
            if (scan_valid) begin
                if (scan_q.size() == 0) begin
                    check("scan_valid_unexpected", 32'(scan_valid), 32'd0);
                end else begin
                    e = scan_q.pop_front();
                    check("scan_data", scan_data, e);
                end
            end
            if (wb.ack) begin
                if (wb_q.size() == 0) begin
                    check("wb_ack_unexpected", 32'(wb.ack), 32'd0);
                end else begin
                    w = wb_q.pop_front();
                    if (w.chk) check("wb_dat_r", wb.dat_r, w.data);
                end
            end
        end
    end

    function automatic logic hit_of(input logic [31:0] adr);
        logic [31:0] base_v;
        base_v = BASE;
        return adr[31:ADDR_W+2] == base_v[31:ADDR_W+2];
    endfunction

    // All tasks start shortly after a rising edge.
    task automatic scan_once(input logic [ADDR_W-1:0] a);
        scan_req  = 1'b1;
        scan_addr = a;
        @(negedge clk);
        check("scan_gnt",      32'(scan_gnt), 32'd1);
        check("scan_mem_en",   32'(mem_en),   32'd1);
        check("scan_mem_we",   32'(mem_we),   32'd0);
        check("scan_mem_addr", 32'(mem_addr), 32'(a));
        scan_q.push_back(ref_mem[a]);
        $display("scan  addr=%03h expect=%08h", a, ref_mem[a]);
        @(posedge clk); #1;
        scan_req = 1'b0;
    endtask

    task automatic wb_access(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, input logic [3:0] sel);
        logic              hit;
        logic [ADDR_W-1:0] w;
        wb_exp_t           e;
        hit = hit_of(adr);
        w   = adr[ADDR_W+1:2];
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
        wb.adr = adr;  wb.dat_w = dat; wb.sel = sel;
        @(negedge clk);
        check("wb_grant_scan_gnt", 32'(scan_gnt), 32'd0);
        check("wb_grant_ack",      32'(wb.ack),   32'd0);
        if (hit) begin
            check("wb_mem_en",   32'(mem_en),   32'd1);
            check("wb_mem_we",   32'(mem_we),   32'(we));
            check("wb_mem_addr", 32'(mem_addr), 32'(w));
            if (we) begin
                check("wb_mem_wmask", 32'(mem_wmask), 32'(sel));
                check("wb_mem_wdata", mem_wdata, dat);
            end
        end else begin
            check("wb_oor_mem_en", 32'(mem_en), 32'd0);
        end
        e.chk  = !hit || !we;
        e.data = hit ? ref_mem[w] : 32'h0;
        wb_q.push_back(e);
        if (hit && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[w][b*8 +: 8] = dat[b*8 +: 8];
        $display("wb    adr=%08h we=%0d dat=%08h sel=%b hit=%0d expect=%08h",
                 adr, we, dat, sel, hit, e.data);
        @(negedge clk);
        check("wb_ack_t1",    32'(wb.ack), 32'd0);
        check("wb_mem_en_t1", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("wb_ack_t2", 32'(wb.ack), 32'd1);
        @(posedge clk); #1;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    // Wishbone read held against a continuous scanout stream.
    task automatic wb_starve(input logic [31:0] adr, input logic [ADDR_W-1:0] sa);
        int   n;
        logic granted;
        wb_exp_t e;
        n = 0; granted = 1'b0;
        scan_req = 1'b1; scan_addr = sa;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = adr; wb.sel = 4'hF;
        for (int c = 0; c < 12 && !granted; c++) begin
            @(negedge clk);
            if (scan_gnt) begin
                check("starve_scan_addr", 32'(mem_addr), 32'(scan_addr));
                scan_q.push_back(ref_mem[scan_addr]);
                n++;
            end else begin
                granted = 1'b1;
                check("starve_wb_mem_en",   32'(mem_en),   32'd1);
                check("starve_wb_mem_we",   32'(mem_we),   32'd0);
                check("starve_wb_mem_addr", 32'(mem_addr), 32'(adr[ADDR_W+1:2]));
                e.chk = 1'b1; e.data = ref_mem[adr[ADDR_W+1:2]];
                wb_q.push_back(e);
            end
            @(posedge clk); #1;
            scan_addr = scan_addr + 1'b1;
        end
        check("starve_scan_grants", 32'(n), 32'(STARVE_MAX));
        check("starve_wb_granted",  32'(granted), 32'd1);
        $display("starve adr=%08h scan_grants=%0d", adr, n);
        // WAIT and ACK: scanout keeps the memory.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("starve_scan_in_txn", 32'(scan_gnt), 32'd1);
            if (scan_gnt) scan_q.push_back(ref_mem[scan_addr]);
            if (c == 1) check("starve_ack", 32'(wb.ack), 32'd1);
            @(posedge clk); #1;
            scan_addr = scan_addr + 1'b1;
        end
        wb.cyc = 1'b0; wb.stb = 1'b0;
        scan_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 512; i++) begin
            v = $urandom;
            sram[i] = v; ref_mem[i] = v;
        end
        sram[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
        sram[1]  = 32'hCAFE_0001; ref_mem[1]  = 32'hCAFE_0001;
        mem_rdata = 32'h0;

        // Reset with requests active: memory port must stay quiet.
        reset_n = 1'b0;
        scan_req = 1'b1; scan_addr = 9'h005;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1;
        wb.adr = BASE; wb.dat_w = 32'hFFFF_FFFF; wb.sel = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_scan_gnt",   32'(scan_gnt),   32'd0);
        check("rst_mem_en",     32'(mem_en),     32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_ack",        32'(wb.ack),     32'd0);
        check("rst_dat_r",      wb.dat_r,        32'h0);
        check("rst_scan_valid", 32'(scan_valid), 32'd0);
        scan_req = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        scan_once(9'h010);
        wb_access(32'h3000_0040, 1'b1, 32'h1234_5678, 4'b0011);
        wb_access(32'h3000_0004, 1'b0, 32'h0, 4'hF);
        wb_access(32'h3000_0040, 1'b0, 32'h0, 4'hF);
        wb_access(32'h4000_0000, 1'b0, 32'h0, 4'hF);
        scan_once(9'h010);
        wb_starve(32'h3000_0004, 9'h020);
        wb_starve(32'h3000_0800 - 32'd4, 9'h1F0);

        // Randomised mix.
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [31:0] adr;
            op  = int'($urandom_range(0, 9));
            adr = BASE | {21'h0, 9'($urandom_range(0, 511)), 2'b00};
            if (op < 3)       scan_once(9'($urandom_range(0, 511)));
            else if (op < 6)  wb_access(adr, 1'b1, $urandom, 4'($urandom_range(0, 15)));
            else if (op < 9)  wb_access(adr, 1'b0, 32'h0, 4'hF);
            else              wb_access(adr ^ 32'h0100_0000, 1'($urandom_range(0, 1)), $urandom, 4'hF);
        end

        // Reset while in WAIT abandons the transaction.
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h3000_0004; wb.sel = 4'hF;
        @(negedge clk);
        check("rstwait_grant_mem_en", 32'(mem_en), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        scan_req = 1'b1; scan_addr = 9'h033;
        @(negedge clk);
        check("rstwait_ack",        32'(wb.ack),     32'd0);
        check("rstwait_dat_r",      wb.dat_r,        32'h0);
        check("rstwait_scan_valid", 32'(scan_valid), 32'd0);
        check("rstwait_scan_gnt",   32'(scan_gnt),   32'd0);
        check("rstwait_mem_en",     32'(mem_en),     32'd0);
        check("rstwait_mem_we",     32'(mem_we),     32'd0);
        check("rstwait_scan_data",  scan_data,       32'h0);
        $display("reset in WAIT applied");
        wb.cyc = 1'b0; wb.stb = 1'b0; scan_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        // FSM back in IDLE: a fresh read is granted at once.
        wb_access(32'h3000_0004, 1'b0, 32'h0, 4'hF);

        repeat (3) @(negedge clk);
        check("scan_q_empty", 32'(scan_q.size()), 32'd0);
        check("wb_q_empty",   32'(wb_q.size()),   32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, framebuffer word-address width (512 x 32-bit words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone byte base of framebuffer window.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive scan grants tolerated while Wishbone waits.
REQ-004 SHALL have port clk  in  1  single clock; all logic synchronous to it.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports wb__cyc, wb__stb, wb__we  in  1 each  Wishbone classic slave controls.
REQ-007 SHALL have ports wb__adr  in  32, wb__dat_w  in  32, sel  in  4  byte address, write data, byte enables.
REQ-008 SHALL have ports wb__dat_r  out  32, wb__ack  out  1  read data, acknowledge.
REQ-009 SHALL have ports scan_req  in  1, scan_addr  in  ADDR_W, scan_gnt  out  1, scan_valid  out  1, scan_data  out  32  scanout read requester.
REQ-010 SHALL have ports mem_en, mem_we  out  1, mem_wmask  out  4, mem_addr  out  ADDR_W, mem_wdata  out  32, mem_rdata  in  32  single-port SRAM, read data valid one cycle after mem_en.

Function
REQ-011 SHALL issue at most one memory access per cycle; mem_en low when no grant.
REQ-012 SHALL treat Wishbone as pending when wb__cyc & wb__stb & FSM in IDLE.
REQ-013 SHALL grant scanout by default when scan_req high; scan_gnt combinational in the request cycle, mem_en=1, mem_we=0, mem_addr=scan_addr.
REQ-014 SHALL grant Wishbone instead when pending and (scan_req low or starve_cnt == STARVE_MAX); scan_gnt low that cycle.
REQ-015 SHALL increment starve_cnt (saturating) on each scan grant while Wishbone pending; clear it on Wishbone grant or when Wishbone not pending.
REQ-016 SHALL assert scan_valid for exactly one cycle, the cycle after a scan grant, with scan_data = mem_rdata.
REQ-017 SHALL decode in-range as wb__adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]; word address = wb__adr[ADDR_W+1:2].
REQ-018 FSM states IDLE, WAIT, ACK: IDLE->WAIT on Wishbone grant; WAIT->ACK unconditionally; ACK->IDLE unconditionally.
REQ-019 In-range write grant SHALL drive mem_we=1, mem_wmask=sel, mem_wdata=wb__dat_w for that single cycle.
REQ-020 In-range read grant SHALL drive mem_we=0; in WAIT, wb__dat_r register SHALL capture mem_rdata.
REQ-021 Out-of-range access SHALL take the IDLE->WAIT path without mem_en; wb__dat_r captures 32'h0.
REQ-022 wb__ack SHALL be a registered one-cycle pulse in ACK, i.e. grant cycle T -> ack at T+2, only if wb__cyc & wb__stb still high; otherwise suppressed (write already committed).
REQ-023 In WAIT/ACK, scanout SHALL remain grantable every cycle (Wishbone not pending).
REQ-024 wb__dat_r SHALL hold its last value outside ACK.

Reset
REQ-025 On reset_n low: FSM=IDLE, starve_cnt=0, wb__ack=0, wb__dat_r=0, scan_valid=0; mem_en, mem_we, scan_gnt forced 0 combinationally.
REQ-026 Reset mid-transaction SHALL abandon it: no wb__ack, no scan_valid after release.

Structure
REQ-027 State enum, default ADDR_W and BASE_ADDR constants SHALL live in shared package gfx_pkg.
REQ-028 Arbitration, counter and FSM SHALL be one flat module; no sub-module.

Verification
REQ-029 Idle bus, scan_req=1 addr 9'h010 with mem_rdata=32'hDEAD_BEEF -> scan_gnt same cycle, scan_valid=1 and scan_data=32'hDEAD_BEEF next cycle.
REQ-030 WB write adr 32'h3000_0040, dat 32'h1234_5678, sel 4'b0011, no scan -> mem_addr 9'h010, mem_wmask 4'b0011 at T, wb__ack at T+2.
REQ-031 WB read adr 32'h3000_0004, memory returns 32'hCAFE_0001 -> wb__dat_r=32'hCAFE_0001 with wb__ack at T+2.
REQ-032 scan_req held high with WB read pending -> exactly 4 scan grants, then Wishbone granted on 5th cycle, starve_cnt back to 0.
REQ-033 WB read adr 32'h4000_0000 -> no mem_en, wb__ack at T+2 with wb__dat_r=0.
REQ-034 reset_n pulsed low in WAIT -> no wb__ack, FSM IDLE, all outputs 0.
